// File: rtl/mul_pkg.sv
// Shared widths and types for the 16x16 pipelined multiplier.
package mul_pkg;

   localparam int OP_W        = 16;
   localparam int PROD_W      = 32;
   localparam int HALF_W      = 8;
   localparam int MUL_LATENCY = 2;

   typedef logic [OP_W-1:0]   operand_t;
   typedef logic [PROD_W-1:0] product_t;

endpackage : mul_pkg

// File: rtl/eight_bit_multiplier.sv
// Combinational unsigned 8x8 -> 16 array multiplier.
// Each row is the multiplicand gated by one multiplier bit (AND terms).
// Rows are shifted into place and accumulated by a ripple adder chain.
module eight_bit_multiplier
   import mul_pkg::*;
(
   input  logic [HALF_W-1:0]   a_i,
   input  logic [HALF_W-1:0]   b_i,
   output logic [2*HALF_W-1:0] p_o
);

   logic [2*HALF_W-1:0] acc;
   logic [2*HALF_W-1:0] row;

   // Accumulate the eight shifted AND rows into the full 16-bit product.
   always_comb begin
      acc = '0;
      row = '0;
      for (int i = 0; i < HALF_W; i++) begin
         row = {{HALF_W{1'b0}}, a_i & {HALF_W{b_i[i]}}} << i;
         acc = acc + row;
      end
      p_o = acc;
   end

endmodule : eight_bit_multiplier

// File: rtl/sixteen_bit_multiplier.sv
// Two-stage pipelined unsigned 16x16 -> 32 multiplier.
// Stage 1 registers four 8x8 partial products; stage 2 registers their
// shifted sum. Invalid slots carry zero partial products, so answer reads 0.
module sixteen_bit_multiplier
   import mul_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     in_valid,
   input  operand_t operator_1,
   input  operand_t operator_2,
   output logic     out_valid,
   output product_t answer
);

   logic [2*HALF_W-1:0] pll_d, plh_d, phl_d, phh_d;
   logic [2*HALF_W-1:0] pll_p1_q, plh_p1_q, phl_p1_q, phh_p1_q;
   logic                vld_p1_q;
   logic [2*HALF_W:0]   mid_sum;
   product_t            answer_d;
   product_t            answer_p2_q;
   logic                vld_p2_q;

   eight_bit_multiplier u_mul_ll (
      .a_i (operator_1[HALF_W-1:0]),
      .b_i (operator_2[HALF_W-1:0]),
      .p_o (pll_d)
   );

   eight_bit_multiplier u_mul_lh (
      .a_i (operator_1[HALF_W-1:0]),
      .b_i (operator_2[OP_W-1:HALF_W]),
      .p_o (plh_d)
   );

   eight_bit_multiplier u_mul_hl (
      .a_i (operator_1[OP_W-1:HALF_W]),
      .b_i (operator_2[HALF_W-1:0]),
      .p_o (phl_d)
   );

   eight_bit_multiplier u_mul_hh (
      .a_i (operator_1[OP_W-1:HALF_W]),
      .b_i (operator_2[OP_W-1:HALF_W]),
      .p_o (phh_d)
   );

   // ---- stage 1: register partial products, zeroed for invalid slots ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pll_p1_q <= '0;
         plh_p1_q <= '0;
         phl_p1_q <= '0;
         phh_p1_q <= '0;
         vld_p1_q <= 1'b0;
      end else begin
         pll_p1_q <= in_valid ? pll_d : '0;
         plh_p1_q <= in_valid ? plh_d : '0;
         phl_p1_q <= in_valid ? phl_d : '0;
         phh_p1_q <= in_valid ? phh_d : '0;
         vld_p1_q <= in_valid;
      end
   end

   // Combine partial products; the middle sum keeps its 17th (carry) bit.
   always_comb begin
      mid_sum  = {1'b0, plh_p1_q} + {1'b0, phl_p1_q};
      answer_d = {phh_p1_q, {(2*HALF_W){1'b0}}}
               + {{(HALF_W-1){1'b0}}, mid_sum, {HALF_W{1'b0}}}
               + {{(2*HALF_W){1'b0}}, pll_p1_q};
   end

   // ---- stage 2: register the final product and its valid ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         answer_p2_q <= '0;
         vld_p2_q    <= 1'b0;
      end else begin
         answer_p2_q <= answer_d;
         vld_p2_q    <= vld_p1_q;
      end
   end

   assign answer    = answer_p2_q;
   assign out_valid = vld_p2_q;

endmodule : sixteen_bit_multiplier

// File: tb/tb_sixteen_bit_multiplier.sv
// Directed and random-stream bench for the 16x16 pipelined multiplier.
module tb_sixteen_bit_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] operator_1;
   logic [15:0] operator_2;
   logic        out_valid;
   logic [31:0] answer;

   logic [7:0]  sa, sb;
   logic [15:0] sp;

   int n_vec = 0;
   int n_err = 0;

   // Two-deep expected pipeline
   logic        ev1, ev2;
   logic [31:0] ea1, ea2;

   sixteen_bit_multiplier dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .operator_1 (operator_1),
      .operator_2 (operator_2),
      .out_valid  (out_valid),
      .answer     (answer)
   );

   eight_bit_multiplier u_sub (
      .a_i (sa),
      .b_i (sb),
      .p_o (sp)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Apply one slot at negedge, clock it, then check the slot from 2 edges ago.
   task automatic step(input string tag, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] e);
      in_valid   = v;
      operator_1 = a;
      operator_2 = b;
      @(posedge clk);
      ev2 = ev1;  ea2 = ea1;
      ev1 = v;    ea1 = v ? e : 32'h0;
      @(negedge clk);
      chk({tag, ".vld"}, {31'b0, out_valid}, {31'b0, ev2});
      chk({tag, ".ans"}, answer, ea2);
   endtask

   task automatic flush();
      for (int i = 0; i < 2; i++) step("flush", 1'b0, 16'h0, 16'h0, 32'h0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rv;
      int          sub_bad;

      rst_n = 1'b0; in_valid = 1'b0; operator_1 = '0; operator_2 = '0;
      ev1 = 1'b0; ev2 = 1'b0; ea1 = '0; ea2 = '0;
      sa = '0; sb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.vld", {31'b0, out_valid}, 32'h0);
      chk("rst.ans", answer, 32'h0);
      rst_n = 1'b1;

      // Corners and cross-byte carries, hand-computed
      step("zero",   1'b1, 16'h0000, 16'h1234, 32'h0000_0000);
      step("one",    1'b1, 16'h0001, 16'hBEEF, 32'h0000_BEEF);
      step("max",    1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
      step("msb",    1'b1, 16'h8000, 16'h0002, 32'h0001_0000);
      step("xcar1",  1'b1, 16'h00FF, 16'hFF00, 32'h00FE_0100);
      step("xcar2",  1'b1, 16'h0101, 16'h0101, 32'h0001_0201);
      step("small",  1'b1, 16'h0003, 16'h0005, 32'h0000_000F);
      step("mixed",  1'b1, 16'h1234, 16'h5678, 32'h0626_0060);
      step("shift8", 1'b1, 16'hFFFF, 16'h0100, 32'h00FF_FF00);
      step("bub",    1'b0, 16'hFFFF, 16'hFFFF, 32'h0);
      step("max1",   1'b1, 16'hFFFF, 16'h0001, 32'h0000_FFFF);
      flush();

      // Reset mid-stream with valid operations in flight
      step("pre1", 1'b1, 16'h1111, 16'h0003, 32'h0000_3333);
      step("pre2", 1'b1, 16'h2222, 16'h0002, 32'h0000_4444);
      in_valid = 1'b1; operator_1 = 16'hFFFF; operator_2 = 16'hFFFF;
      rst_n = 1'b0;
      #1;
      chk("arst.vld", {31'b0, out_valid}, 32'h0);
      chk("arst.ans", answer, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ev1 = 1'b0; ev2 = 1'b0; ea1 = '0; ea2 = '0;
      step("post1", 1'b1, 16'h0002, 16'h0003, 32'h0000_0006);
      step("post2", 1'b0, 16'h0000, 16'h0000, 32'h0);
      step("post3", 1'b0, 16'h0000, 16'h0000, 32'h0);
      step("post4", 1'b0, 16'h0000, 16'h0000, 32'h0);

      // Back-to-back random stream
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         step("strm", 1'b1, ra, rb, {16'h0, ra} * {16'h0, rb});
      end

      // Random bubbles
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rv = 1'($urandom);
         step("bubl", rv, ra, rb, {16'h0, ra} * {16'h0, rb});
      end
      flush();

      // Exhaustive 8x8 sub-multiplier
      sub_bad = 0;
      for (int x = 0; x < 256; x++) begin
         for (int y = 0; y < 256; y++) begin
            sa = 8'(x);
            sb = 8'(y);
            #1;
            if (sp !== 16'(x * y)) begin
               if (sub_bad < 4)
                  $display("sub8 case %0d*%0d got 0x%04h", x, y, sp);
               sub_bad++;
            end
         end
      end
      chk("sub8.bad", 32'(sub_bad), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sixteen_bit_multiplier
